// File: rtl/aes_sub_shift_stage_if.sv
// Handshake bundle for the AES SubBytes+ShiftRows stage.
// Carries the input-state stream and the output-state stream.
interface aes_sub_shift_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/aes_sub_shift_stage.sv
// Iterative AES-128 SubBytes + ShiftRows stage: LANES shared S-boxes walk the
// captured state in 16/LANES chunks, scattering results to ShiftRows positions.
module aes_sub_shift_stage #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_sub_shift_stage_if.slave  bus,
  output logic                  busy
);

  localparam int CHUNKS = 16 / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_sub_shift_stage: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     src_q;
  logic [127:0]     res_q;
  logic             out_valid_q;

  logic [3:0] src_idx  [LANES];
  logic [3:0] dst_idx  [LANES];
  logic [7:0] sub_byte [LANES];

  // Byte i sits at row i%4, column i/4; ShiftRows moves it to column (c-r) mod 4.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      src_idx[l]  = 4'(int'(cnt) * LANES + l);
      dst_idx[l]  = {2'(src_idx[l][3:2] - src_idx[l][1:0]), src_idx[l][1:0]};
      sub_byte[l] = sbox(src_q[127 - 8*int'(src_idx[l]) -: 8]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the 128-bit buffers are plain flops and take the async
  // reset like the control state, so no stale data survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      src_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            src_q <= bus.state_in;
            cnt   <= '0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            res_q[127 - 8*int'(dst_idx[l]) -: 8] <= sub_byte[l];
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = res_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Directed bench for aes_sub_shift_stage: FIPS-197 vectors, latency for several
// LANES values, backpressure, back-to-back traffic and reset abort.
module tb_aes_sub_shift_stage;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_EXP  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
  localparam logic [127:0] ZERO_EXP = 128'h63636363636363636363636363636363;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic         out_ready;
  logic         busy1, busy2, busy4, busy16;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  aes_sub_shift_stage_if bus1 ();
  aes_sub_shift_stage_if bus2 ();
  aes_sub_shift_stage_if bus4 ();
  aes_sub_shift_stage_if bus16 ();

  assign bus1.in_valid  = in_valid; assign bus1.state_in  = state_in; assign bus1.out_ready  = out_ready;
  assign bus2.in_valid  = in_valid; assign bus2.state_in  = state_in; assign bus2.out_ready  = out_ready;
  assign bus4.in_valid  = in_valid; assign bus4.state_in  = state_in; assign bus4.out_ready  = out_ready;
  assign bus16.in_valid = in_valid; assign bus16.state_in = state_in; assign bus16.out_ready = out_ready;

  aes_sub_shift_stage #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1),  .busy(busy1));
  aes_sub_shift_stage #(.LANES(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2),  .busy(busy2));
  aes_sub_shift_stage #(.LANES(4))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus4),  .busy(busy4));
  aes_sub_shift_stage #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction through the LANES=4 instance with out_ready already high.
  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] dexp);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(bus4.in_ready), 128'(1));
    in_valid = 1'b1;
    state_in = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = ~din;
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(4));
    check({tag, "_data"}, bus4.state_out, dexp);
    @(posedge clk); #1;
    check({tag, "_drop"}, 128'(bus4.out_valid), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat1, lat2, lat4, lat16, lat;
    logic [127:0] dat1, dat2, dat4, dat16;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    #12;
    check("rst_in_ready",  128'(bus4.in_ready),  128'(1));
    check("rst_out_valid", 128'(bus4.out_valid), 128'(0));
    check("rst_busy",      128'(busy4),          128'(0));
    check("rst_state_out", bus4.state_out,       128'(0));
    @(negedge clk); rst_n = 1'b1;

    // Same input into every LANES variant; latency must be 16/LANES.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = SEQ_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0; lat16 = 0;
    dat1 = '0; dat2 = '0; dat4 = '0; dat16 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus1.out_valid  && lat1  == 0) begin lat1  = k; dat1  = bus1.state_out;  end
      if (bus2.out_valid  && lat2  == 0) begin lat2  = k; dat2  = bus2.state_out;  end
      if (bus4.out_valid  && lat4  == 0) begin lat4  = k; dat4  = bus4.state_out;  end
      if (bus16.out_valid && lat16 == 0) begin lat16 = k; dat16 = bus16.state_out; end
    end
    check("lanes1_lat",   128'(lat1),  128'(16));
    check("lanes2_lat",   128'(lat2),  128'(8));
    check("lanes4_lat",   128'(lat4),  128'(4));
    check("lanes16_lat",  128'(lat16), 128'(1));
    check("lanes1_data",  dat1,  SEQ_EXP);
    check("lanes2_data",  dat2,  SEQ_EXP);
    check("lanes4_data",  dat4,  SEQ_EXP);
    check("lanes16_data", dat16, SEQ_EXP);

    run_one("fips", FIPS_IN, FIPS_EXP);
    run_one("zero", 128'(0), ZERO_EXP);
    run_one("seq",  SEQ_IN,  SEQ_EXP);

    // Backpressure, with new input offered and state_in scrambled while busy.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = FIPS_IN;
    @(posedge clk); #1;
    state_in = 128'hffeeddccbbaa99887766554433221100;
    check("bp_busy", 128'(busy4), 128'(1));
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 128'(lat), 128'(4));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 128'(bus4.out_valid), 128'(1));
      check("bp_hold_data",  bus4.state_out,        FIPS_EXP);
      check("bp_hold_ready", 128'(bus4.in_ready),   128'(0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(bus4.out_valid), 128'(0));
    check("bp_release_ready", 128'(bus4.in_ready),  128'(1));

    // Back-to-back: in_valid stays high, the second state waits for the IDLE cycle.
    @(negedge clk);
    in_valid = 1'b1;
    state_in = SEQ_IN;
    @(posedge clk); #1;
    state_in = 128'(0);
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_lat",   128'(lat),            128'(4));
    check("b2b_first_data",  bus4.state_out,       SEQ_EXP);
    check("b2b_done_ready",  128'(bus4.in_ready),  128'(0));
    @(posedge clk); #1;
    check("b2b_idle_valid",  128'(bus4.out_valid), 128'(0));
    check("b2b_idle_ready",  128'(bus4.in_ready),  128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_busy", 128'(busy4), 128'(1));
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_second_lat",  128'(lat),      128'(4));
    check("b2b_second_data", bus4.state_out, ZERO_EXP);
    @(posedge clk); #1;

    // Reset while in SUB with cnt=2 aborts at once.
    @(negedge clk);
    in_valid = 1'b1;
    state_in = FIPS_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_busy", 128'(busy4), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(bus4.out_valid), 128'(0));
    check("abort_in_ready",  128'(bus4.in_ready),  128'(1));
    check("abort_busy",      128'(busy4),          128'(0));
    check("abort_state_out", bus4.state_out,       128'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_spurious", 128'(bus4.out_valid), 128'(0));
    end
    run_one("post_abort", FIPS_IN, FIPS_EXP);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
